// File: rtl/linebuff_scheduler_if.sv
// Bundle between the line-buffer scheduler and its scanout/renderer peers.
// Handshake: rend_start/rend_abort are single-cycle pulses from the scheduler;
// rend_done is a single-cycle pulse from the renderer, sampled on the rising clock
// edge; there is no back-pressure, so each pulse is consumed in the cycle it is high.
interface linebuff_scheduler_if #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
);
    logic              pix_ce;
    logic [8:0]        hcount;
    logic [8:0]        vcount;
    logic              hblank;
    logic              vblank;
    logic              scan_valid;
    logic              scan_bank;
    logic [ADDR_W-1:0] scan_addr;
    logic              rend_bank;
    logic [7:0]        rend_line;
    logic              rend_start;
    logic              rend_abort;
    logic              rend_done;
    logic              frame_start;
    logic              underrun;
    logic [CNT_W-1:0]  underrun_cnt;
    logic              fsm_busy;     // debug view of the render FSM (1 = BUSY)

    // Scheduler side.
    modport master (
        input  pix_ce, rend_done,
        output hcount, vcount, hblank, vblank, scan_valid, scan_bank, scan_addr,
               rend_bank, rend_line, rend_start, rend_abort, frame_start,
               underrun, underrun_cnt, fsm_busy
    );

    // Scanout / renderer / timing-source side.
    modport slave (
        output pix_ce, rend_done,
        input  hcount, vcount, hblank, vblank, scan_valid, scan_bank, scan_addr,
               rend_bank, rend_line, rend_start, rend_abort, frame_start,
               underrun, underrun_cnt, fsm_busy
    );
endinterface

// File: rtl/linebuff_scheduler.sv
// Video timing generator and ping-pong line-buffer controller.
// Scanout reads the front bank while the renderer fills the back bank; banks swap
// at each boundary entering an active line, and a render still in flight at a
// swap is aborted and counted as an underrun.
module linebuff_scheduler #(
    parameter int H_ACTIVE = 320,
    parameter int H_BLANK  = 80,
    parameter int V_ACTIVE = 240,
    parameter int V_BLANK  = 80,
    parameter int ADDR_W   = 9,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    linebuff_scheduler_if.master bus_if
);

    localparam int         H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int         V_TOTAL = V_ACTIVE + V_BLANK;
    localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT9  = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT9  = 9'(V_ACTIVE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Timing counters
    logic [8:0]       hcount_q, hcount_d;
    logic [8:0]       vcount_q, vcount_d;

    // Bank / request / status registers
    logic             scan_bank_q, scan_bank_d;
    logic [7:0]       rend_line_q, rend_line_d;
    logic             rend_start_q, rend_start_d;
    logic             rend_abort_q, rend_abort_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;
    logic [CNT_W-1:0] ucnt_q, ucnt_d;
    logic             kick_q, kick_d;
    state_t           state_q, state_d;

    // Boundary decode
    logic       line_end;   // this cycle's pixel advance wraps hcount
    logic [8:0] v_next;     // vcount after the wrap
    logic [8:0] v_target;   // line to render during v_next
    logic       swap;       // boundary entering an active line
    logic       req;        // boundary that requests a new line
    logic       done_ok;    // rend_done that counts (not coincident with rend_start)

    assign line_end = bus_if.pix_ce && (hcount_q == H_LAST);
    assign v_next   = (vcount_q == V_LAST) ? 9'd0 : vcount_q + 9'd1;
    assign v_target = (v_next == V_LAST) ? 9'd0 : v_next + 9'd1;
    assign swap     = line_end && (v_next < V_ACT9);
    assign req      = line_end && (v_target < V_ACT9);
    assign done_ok  = bus_if.rend_done && !rend_start_q;

    // Next-state for the pixel/line counters; frozen while pix_ce is low.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (bus_if.pix_ce) begin
            hcount_d = line_end ? 9'd0 : hcount_q + 9'd1;
        end
        if (line_end) begin
            vcount_d = v_next;
        end
    end

    // Render FSM next-state plus bank swap, request, underrun and frame pulses.
    always_comb begin
        state_d       = state_q;
        kick_d        = kick_q;
        scan_bank_d   = scan_bank_q;
        rend_line_d   = rend_line_q;
        rend_start_d  = 1'b0;
        rend_abort_d  = 1'b0;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        ucnt_d        = ucnt_q;

        if (swap) begin
            scan_bank_d = ~scan_bank_q;
        end

        if (line_end && (v_next == 9'd0)) begin
            frame_start_d = 1'b1;
        end

        // A render still running when its bank is handed to scanout is cancelled.
        if (swap && (state_q == ST_BUSY) && !done_ok) begin
            underrun_d   = 1'b1;
            rend_abort_d = 1'b1;
            if (ucnt_q != '1) begin
                ucnt_d = ucnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_BUSY: if (underrun_d || done_ok) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A new request wins over completion/abort: the FSM ends BUSY.
        if (kick_q) begin
            rend_start_d = 1'b1;
            rend_line_d  = 8'd0;
            kick_d       = 1'b0;
            state_d      = ST_BUSY;
        end else if (req) begin
            rend_start_d = 1'b1;
            rend_line_d  = 8'(v_target);
            state_d      = ST_BUSY;
        end
    end

    // State registers; reset leaves the last blank line current so the first
    // boundary enters line 0 of a fresh frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= 9'd0;
            vcount_q      <= V_LAST;
            scan_bank_q   <= 1'b0;
            rend_line_q   <= 8'd0;
            rend_start_q  <= 1'b0;
            rend_abort_q  <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            ucnt_q        <= '0;
            kick_q        <= 1'b1;
            state_q       <= ST_IDLE;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            scan_bank_q   <= scan_bank_d;
            rend_line_q   <= rend_line_d;
            rend_start_q  <= rend_start_d;
            rend_abort_q  <= rend_abort_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            ucnt_q        <= ucnt_d;
            kick_q        <= kick_d;
            state_q       <= state_d;
        end
    end

    assign bus_if.hcount       = hcount_q;
    assign bus_if.vcount       = vcount_q;
    assign bus_if.hblank       = (hcount_q >= H_ACT9);
    assign bus_if.vblank       = (vcount_q >= V_ACT9);
    assign bus_if.scan_valid   = !bus_if.hblank && !bus_if.vblank;
    assign bus_if.scan_addr    = bus_if.scan_valid ? ADDR_W'(hcount_q) : '0;
    assign bus_if.scan_bank    = scan_bank_q;
    assign bus_if.rend_bank    = ~scan_bank_q;
    assign bus_if.rend_line    = rend_line_q;
    assign bus_if.rend_start   = rend_start_q;
    assign bus_if.rend_abort   = rend_abort_q;
    assign bus_if.frame_start  = frame_start_q;
    assign bus_if.underrun     = underrun_q;
    assign bus_if.underrun_cnt = ucnt_q;
    assign bus_if.fsm_busy     = (state_q == ST_BUSY);

endmodule

// File: tb/tb_linebuff_scheduler.sv
// Bench for linebuff_scheduler on a reduced raster (12x9 total, 8x6 active) with
// a 2-bit underrun counter, compared every cycle against a position-based model.
module tb_linebuff_scheduler;

    localparam int HA = 8;
    localparam int HB = 4;
    localparam int VA = 6;
    localparam int VB = 3;
    localparam int AW = 4;
    localparam int CW = 2;
    localparam int HT = HA + HB;
    localparam int VT = VA + VB;
    localparam int FRAME = HT * VT;
    localparam int UMAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic rst_next;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    linebuff_scheduler_if #(.ADDR_W(AW), .CNT_W(CW)) lb_if ();

    linebuff_scheduler #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (lb_if)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Position is the number of pixel advances since reset; everything else
    // follows from it and from the renderer's request/done history.
    int m_p;
    int m_swaps;
    bit m_pending;
    bit m_kick;
    bit m_start;
    bit m_under;
    bit m_frame;
    int m_line;
    int m_ucnt;

    function automatic int m_h();
        return m_p % HT;
    endfunction

    function automatic int m_v();
        return (VT - 1 + m_p / HT) % VT;
    endfunction

    task automatic model_reset();
        m_p = 0; m_swaps = 0; m_pending = 0; m_kick = 1;
        m_start = 0; m_under = 0; m_frame = 0; m_line = 0; m_ucnt = 0;
    endtask

    task automatic model_step(input bit pix, input bit done);
        bit done_ok, boundary, n_start, n_under, n_frame;
        int vn, t, n_line;
        if (!rst_n) begin
            model_reset();
            return;
        end
        done_ok  = done && !m_start;
        boundary = pix && (m_h() == HT - 1);
        n_start = 0; n_under = 0; n_frame = 0; n_line = m_line;
        if (pix) m_p++;
        if (boundary) begin
            vn = m_v();
            if (vn < VA) begin
                m_swaps++;
                if (m_pending && !done_ok) begin
                    n_under = 1;
                    if (m_ucnt < UMAX) m_ucnt++;
                end
            end
            t = (vn + 1) % VT;
            if (t < VA) begin
                n_start = 1;
                n_line  = t;
            end
            n_frame = (vn == 0);
        end
        if (m_kick) begin
            n_start = 1;
            n_line  = 0;
            m_kick  = 0;
        end
        if (n_start)      m_pending = 1;
        else if (n_under) m_pending = 0;
        else if (done_ok) m_pending = 0;
        m_start = n_start; m_under = n_under; m_frame = n_frame; m_line = n_line;
    endtask

    task automatic check_all();
        int h, v;
        bit valid;
        h = m_h();
        v = m_v();
        valid = (h < HA) && (v < VA);
        check_eq("hcount",       32'(lb_if.hcount),       32'(h));
        check_eq("vcount",       32'(lb_if.vcount),       32'(v));
        check_eq("hblank",       32'(lb_if.hblank),       32'(h >= HA));
        check_eq("vblank",       32'(lb_if.vblank),       32'(v >= VA));
        check_eq("scan_valid",   32'(lb_if.scan_valid),   32'(valid));
        check_eq("scan_addr",    32'(lb_if.scan_addr),    valid ? 32'(h) : 32'd0);
        check_eq("scan_bank",    32'(lb_if.scan_bank),    32'(m_swaps % 2));
        check_eq("rend_bank",    32'(lb_if.rend_bank),    32'(1 - (m_swaps % 2)));
        check_eq("rend_line",    32'(lb_if.rend_line),    32'(m_line));
        check_eq("rend_start",   32'(lb_if.rend_start),   32'(m_start));
        check_eq("rend_abort",   32'(lb_if.rend_abort),   32'(m_under));
        check_eq("underrun",     32'(lb_if.underrun),     32'(m_under));
        check_eq("frame_start",  32'(lb_if.frame_start),  32'(m_frame));
        check_eq("underrun_cnt", 32'(lb_if.underrun_cnt), 32'(m_ucnt));
        check_eq("fsm_busy",     32'(lb_if.fsm_busy),     32'(m_pending));
    endtask

    // ---------------- driver (pixel enable + behavioural renderer) ----------------
    int cyc;
    int pix_div;          // 0 = random pix_ce, else 1-in-pix_div
    int done_delay;       // 0 = renderer never answers on its own
    bit rand_delay;
    bit rand_done;
    bit done_on_boundary;
    int skip_line;
    int done_at;
    int n_starts;
    int n_unders;

    task automatic cycle();
        bit pix, done;
        int d;
        @(negedge clk);
        rst_n = rst_next;
        if (pix_div == 0) pix = ($urandom_range(0, 1) == 1);
        else              pix = ((cyc % pix_div) == 0);
        done = 0;
        if (rand_done && ($urandom_range(0, 5) == 0)) done = 1;
        if (cyc == done_at) done = 1;
        if (done_on_boundary && pix && (m_h() == HT - 1)) done = 1;
        d = rand_delay ? int'($urandom_range(2, 14)) : done_delay;
        if (m_start && rst_n && (d > 0) && (m_line != skip_line)) done_at = cyc + d;
        lb_if.pix_ce    = pix;
        lb_if.rend_done = done;
        model_step(pix, done);
        cyc++;
        @(posedge clk);
        #1;
        check_all();
        if (lb_if.rend_start) n_starts++;
        if (lb_if.underrun)   n_unders++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- sequence ----------------
    initial begin
        int guard;
        n_checks = 0; n_errors = 0; cyc = 0;
        pix_div = 1; done_delay = 5; rand_delay = 0; rand_done = 0;
        done_on_boundary = 0; skip_line = -1; done_at = -1;
        n_starts = 0; n_unders = 0;
        rst_n = 1'b0; rst_next = 1'b0;
        lb_if.pix_ce = 1'b0; lb_if.rend_done = 1'b0;
        model_reset();

        // Reset state held for a few clocks.
        run(3);

        // Release: kick, first boundary, then steady frames with a fast renderer.
        rst_next = 1'b1;
        run(1);
        check_eq("kick_start", 32'(lb_if.rend_start), 32'd1);
        check_eq("kick_line",  32'(lb_if.rend_line),  32'd0);
        run(FRAME - 1);
        n_starts = 0; n_unders = 0;
        run(2 * FRAME);
        check_eq("starts_2_frames", 32'(n_starts), 32'(2 * VA));
        check_eq("no_underruns",    32'(n_unders), 32'd0);
        check_eq("ucnt_zero",       32'(lb_if.underrun_cnt), 32'd0);

        // Renderer ignores line 3: one underrun on entering line 3.
        skip_line = 3;
        n_unders = 0;
        run(FRAME);
        check_eq("skip_underruns", 32'(n_unders), 32'd1);
        check_eq("skip_ucnt",      32'(lb_if.underrun_cnt), 32'd1);
        skip_line = -1;
        run(FRAME);

        // rend_done only on boundary cycles: counts as done every time.
        done_delay = 0; done_on_boundary = 1;
        n_unders = 0; n_starts = 0;
        run(FRAME);
        check_eq("bnd_underruns", 32'(n_unders), 32'd0);
        check_eq("bnd_starts",    32'(n_starts), 32'(VA));

        // Renderer silent: every swap underruns and the counter saturates.
        done_on_boundary = 0;
        run(2 * FRAME);
        check_eq("ucnt_saturated", 32'(lb_if.underrun_cnt), 32'(UMAX));

        // pix_ce 1-in-4, then asynchronous reset at (5,3).
        pix_div = 4; done_delay = 5; done_at = -1;
        run(2 * FRAME * 4);
        guard = 0;
        while (!((m_h() == 5) && (m_v() == 3)) && (guard < 4000)) begin
            cycle();
            guard++;
        end
        check_eq("reset_point_reached", 32'(guard < 4000), 32'd1);
        #2;
        rst_n = 1'b0; rst_next = 1'b0;
        #1;
        model_reset();
        done_at = -1;
        check_all();
        run(2);
        rst_next = 1'b1;
        run(1);
        check_eq("rekick_start", 32'(lb_if.rend_start), 32'd1);
        check_eq("rekick_line",  32'(lb_if.rend_line),  32'd0);
        run(FRAME * 4);

        // Randomised pix_ce, renderer latency and stray done pulses.
        pix_div = 0; rand_delay = 1; rand_done = 1;
        run(6 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (compared %0d)", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/linebuff_scheduler.md
Name: linebuff_scheduler

Overview:
- Video timing and ping-pong line-buffer controller for the 320x240 display pipeline.
- Generates pixel and line counters, including blanking.
- Points scanout at the front line-buffer bank and the BG/sprite renderer at the back bank.
- Issues per-line render requests, swaps banks at line boundaries, and detects and counts renderer underruns.

Parameters:
- H_ACTIVE, 320, visible pixels per line
- H_BLANK, 80, blank pixels per line (H_TOTAL = 400)
- V_ACTIVE, 240, visible lines per frame
- V_BLANK, 80, blank lines per frame (V_TOTAL = 320)
- ADDR_W, 9, line-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE
- CNT_W, 16, underrun counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel clock enable; counters advance only when high
- hcount  out  9  horizontal position, 0..H_TOTAL-1
- vcount  out  9  vertical position, 0..V_TOTAL-1
- hblank  out  1  hcount >= H_ACTIVE
- vblank  out  1  vcount >= V_ACTIVE
- scan_valid  out  1  !hblank && !vblank
- scan_bank  out  1  bank scanout reads
- scan_addr  out  ADDR_W  read address; equals hcount when scan_valid, else 0
- rend_bank  out  1  bank renderer writes; always ~scan_bank
- rend_line  out  8  line number the renderer is to produce, 0..V_ACTIVE-1
- rend_start  out  1  one-cycle render request
- rend_abort  out  1  one-cycle pulse; in-flight render cancelled
- rend_done  in  1  one-cycle pulse from renderer; line complete
- frame_start  out  1  one-cycle pulse on entering (hcount=0, vcount=0)
- underrun  out  1  one-cycle pulse on swap while render incomplete
- underrun_cnt  out  CNT_W  saturating underrun count

Behaviour:
- Reset values:
  - hcount=0, vcount=V_TOTAL-1, scan_bank=0, rend_bank=1, rend_line=0.
  - rend_start, rend_abort, frame_start and underrun = 0; underrun_cnt=0.
  - FSM=IDLE, kick flag=1.
- Counters:
  - On pix_ce: hcount increments and wraps H_TOTAL-1 -> 0.
  - On that wrap ("line boundary"), vcount increments and wraps V_TOTAL-1 -> 0.
  - hblank, vblank, scan_valid and scan_addr are combinational from the counter registers (zero latency).
- Kick:
  - First clock after reset release with kick=1: rend_start=1, rend_line=0, FSM -> BUSY, kick -> 0.
  - The kick does not depend on pix_ce.
- Line boundary, next line vn = new vcount value:
  - Swap: if vn < V_ACTIVE, scan_bank and rend_bank toggle on the same edge.
  - Request: target t = (vn+1) mod V_TOTAL. If t < V_ACTIVE: rend_start=1 for one cycle, rend_line=t, FSM -> BUSY.
  - Requests therefore occur entering lines 319 and 0..238; none entering lines 239..318.
- Render FSM, states IDLE and BUSY:
  - IDLE -> BUSY on rend_start.
  - BUSY -> IDLE on rend_done.
  - rend_done in IDLE is ignored.
- Underrun:
  - Condition: at a swapping boundary, FSM=BUSY and rend_done is not high in that same cycle.
  - Response: underrun=1, rend_abort=1, underrun_cnt += 1 (saturates at all-ones), and the swap still happens.
  - If a new request is issued on that boundary, FSM stays BUSY.
  - BUSY at a non-swapping boundary (vn >= V_ACTIVE) is not an underrun; FSM stays BUSY.
- Simultaneous events:
  - rend_done coincident with the boundary counts as done: no underrun, and the new rend_start is issued normally.
  - rend_done coincident with rend_start (any cycle) is ignored; the FSM ends BUSY.
- frame_start pulses the cycle after the counters move to (0,0). underrun, rend_abort and rend_start are registered with the same one-cycle timing.
- Reset mid-frame asynchronously returns everything to reset values; the kick re-issues line 0.
- pix_ce low freezes counters and blocks boundary events; the FSM still accepts rend_done.

Test Plan:
- Release reset, pix_ce=1, renderer answers rend_done 100 cycles after each rend_start.
  - Required: kick rend_start line 0 on the first cycle.
  - Required: first line boundary gives vcount 0, scan_bank=1, rend_start line 1, frame_start=1.
  - Required: 240 requests per frame, underrun_cnt stays 0.
- Free-run 2 frames: hcount period 400 and vcount period 320×400 = 128000 cycles; hblank high for hcount 320..399; scan_addr=0 whenever !scan_valid.
- Renderer never answers line 5: entering line 5 produces underrun=1 and rend_abort=1, underrun_cnt=1, banks still toggle, rend_start line 6 issued.
- rend_done asserted exactly on the boundary cycle: no underrun, the next rend_start is issued, FSM ends BUSY.
- Force underrun_cnt to 0xFFFF via 65536+ underruns (or CNT_W=2 build, 5 underruns): count holds at max.
- pix_ce toggled 1-in-4: all periods scale ×4. Assert rst_n low at hcount=200, vcount=100: outputs return to reset values immediately, and the kick re-issues line 0 after release.
